// File: rtl/ttfs_charge_scheduler.sv
// ttfs_charge_scheduler: pops AER spikes, sweeps neuron read/write pairs, then runs one charge sweep per tick.
// Optional perf counters are built when TTFS_SCHED_PERF_EN is defined.
module ttfs_charge_scheduler #(
  parameter int N          = 256,
  parameter int M          = 8,
  parameter int INPUT_RESO = 8,
  parameter int CHARGE_MAX = 31
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start_i,
  input  logic [M-1:0] max_neuron_i,
  input  logic         fifo_empty_i,
  output logic         fifo_r_en_o,
  input  logic [M-1:0] fifo_r_data_i,
  input  logic         spikecore_done_i,
  input  logic         next_tick_i,
  input  logic         inference_done_i,
  output logic [M-1:0] count_o,
  output logic [M-1:0] neuron_idx_o,
  output logic         neuron_event_read_o,
  output logic         neuron_event_write_o,
  output logic         neuron_tref_o,
  output logic         charge_enable_o,
  output logic [4:0]   charge_count_o,
  output logic         busy_o,
  output logic         tick_done_o,
`ifdef TTFS_SCHED_PERF_EN
  output logic [31:0]  perf_cycles_o,
  output logic [15:0]  perf_events_o,
`endif
  output logic         irq_o
);
  typedef enum logic [3:0] {IDLE, POP, LATCH, RD, WR, CH_RD, CH_WR, WAIT_TICK, DONE} state_t;
  if (N != (1 << M) || INPUT_RESO < 1 || CHARGE_MAX > 31) begin : g_bad_cfg
    $error("ttfs_charge_scheduler: inconsistent parameters");
  end
  state_t state_q, state_d;
  logic [M-1:0] count_q, count_d, idx_q, idx_d;
  logic [4:0] chg_q, chg_d;
  logic stop_q, stop_d, last, stop;
  assign last = count_q == max_neuron_i;
  assign stop = stop_q | inference_done_i;
  assign stop_d = (state_q == RD || state_q == CH_RD) && inference_done_i;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d = idx_q;
    chg_d = chg_q;
    fifo_r_en_o = 1'b0;
    neuron_event_read_o = 1'b0;
    neuron_event_write_o = 1'b0;
    tick_done_o = 1'b0;
    irq_o = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = POP;
        count_d = '0;
        idx_d = '0;
        chg_d = '0;
      end
      POP: begin
        if (inference_done_i) state_d = DONE;
        else if (!fifo_empty_i) begin
          fifo_r_en_o = 1'b1;
          state_d = LATCH;
        end else if (spikecore_done_i) begin
          count_d = '0;
          state_d = CH_RD;
        end
      end
      LATCH: begin
        if (inference_done_i) state_d = DONE;
        else begin
          idx_d = fifo_r_data_i;
          count_d = '0;
          state_d = RD;
        end
      end
      RD, CH_RD: begin
        neuron_event_read_o = 1'b1;
        state_d = state_q == RD ? WR : CH_WR;
      end
      WR, CH_WR: begin
        neuron_event_write_o = 1'b1;
        count_d = last ? count_q : count_q + 1'b1;
        tick_done_o = last && state_q == CH_WR;
        // Charge steps stop counting once saturated
        chg_d = tick_done_o && chg_q != 5'(CHARGE_MAX) ? chg_q + 5'd1 : chg_q;
        state_d = stop ? DONE : !last ? (state_q == WR ? RD : CH_RD) : (state_q == WR ? POP : WAIT_TICK);
      end
      WAIT_TICK: state_d = inference_done_i ? DONE : next_tick_i ? POP : WAIT_TICK;
      DONE: begin
        irq_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q <= '0;
      chg_q <= '0;
      stop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q <= idx_d;
      chg_q <= chg_d;
      stop_q <= stop_d;
    end
  end
  assign count_o = count_q;
  assign neuron_idx_o = idx_q;
  assign charge_count_o = chg_q;
  assign busy_o = state_q != IDLE;
  assign neuron_tref_o = state_q == CH_RD || state_q == CH_WR;
  assign charge_enable_o = neuron_tref_o;
`ifdef TTFS_SCHED_PERF_EN
  logic [31:0] cyc_q;
  logic [15:0] ev_q;
  always_ff @(posedge CLK) begin
    if (RST || (start_i && state_q == IDLE)) begin
      cyc_q <= '0;
      ev_q <= '0;
    end else begin
      cyc_q <= busy_o && !(&cyc_q) ? cyc_q + 32'd1 : cyc_q;
      ev_q <= fifo_r_en_o && !(&ev_q) ? ev_q + 16'd1 : ev_q;
    end
  end
  assign perf_cycles_o = cyc_q;
  assign perf_events_o = ev_q;
`endif
endmodule
